md_unit: RTL

- Multiply/divide responder for the pipelined MIPS core.
- The E stage issues MULT/MULTU/DIV/DIVU/MTHI/MTLO requests via a start/op handshake.
- The unit holds HI/LO and raises busy for the fixed instruction latency. The hazard unit stalls MFHI/MFLO and new MD ops while start or busy is high.
- It is the servicing end of the core's MD request interface.

---
 rtl/md_pkg.sv | 17 +
 rtl/md_div_core.sv | 35 +++
 rtl/md_unit.sv | 128 ++++++++++++
 3 files changed

// File: rtl/md_pkg.sv
// Shared opcode and state definitions for the multiply/divide unit.
// The decoder and hazard unit import the same op codes from here.
package md_pkg;

    localparam logic [2:0] MD_MULT  = 3'd0;
    localparam logic [2:0] MD_MULTU = 3'd1;
    localparam logic [2:0] MD_DIV   = 3'd2;
    localparam logic [2:0] MD_DIVU  = 3'd3;
    localparam logic [2:0] MD_MTHI  = 3'd4;
    localparam logic [2:0] MD_MTLO  = 3'd5;

    typedef enum logic {
        MD_IDLE = 1'b0,
        MD_RUN  = 1'b1
    } md_state_e;

endpackage

// File: rtl/md_div_core.sv
// Combinational 32-bit divide, signed or unsigned, with MIPS sign fix-up:
// quotient truncates toward zero, remainder takes the dividend's sign.
module md_div_core (
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    input  logic        signed_i,
    output logic [31:0] quot_o,
    output logic [31:0] rem_o,
    output logic        dbz_o
);

    logic        neg_a;
    logic        neg_b;
    logic [31:0] mag_a;
    logic [31:0] mag_b;
    logic [31:0] divisor;
    logic [31:0] uquot;
    logic [31:0] urem;

    assign neg_a = signed_i & a_i[31];
    assign neg_b = signed_i & b_i[31];
    assign mag_a = neg_a ? (32'd0 - a_i) : a_i;
    assign mag_b = neg_b ? (32'd0 - b_i) : b_i;

    // Magnitude of 0x80000000 is itself as unsigned, so the overflow case
    // 0x80000000 / -1 naturally yields quotient 0x80000000, remainder 0.
    assign dbz_o   = (b_i == '0);
    assign divisor = dbz_o ? 32'd1 : mag_b;
    assign uquot   = mag_a / divisor;
    assign urem    = mag_a % divisor;

    assign quot_o = (neg_a ^ neg_b) ? (32'd0 - uquot) : uquot;
    assign rem_o  = neg_a ? (32'd0 - urem) : urem;

endmodule

// File: rtl/md_unit.sv
// Multiply/divide responder: owns HI/LO, computes the result at start into
// pending registers and commits it after the fixed instruction latency.
module md_unit #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo
);
    import md_pkg::*;

    localparam int unsigned MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int unsigned CNT_W      = $clog2(MAX_CYCLES + 1);

    md_state_e          state_q;
    logic               busy_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [31:0]        hi_q;
    logic [31:0]        lo_q;
    logic [31:0]        pend_hi_q;
    logic [31:0]        pend_lo_q;
    logic               pend_we_q;

    logic [31:0]        pend_hi_d;
    logic [31:0]        pend_lo_d;
    logic               pend_we_d;

    logic [63:0]        prod_s;
    logic [63:0]        prod_u;
    logic [31:0]        div_quot;
    logic [31:0]        div_rem;
    logic               div_dbz;
    logic               is_md_op;

    assign prod_s   = {{32{a[31]}}, a} * {{32{b[31]}}, b};
    assign prod_u   = {32'd0, a} * {32'd0, b};
    assign is_md_op = (op == MD_MULT) || (op == MD_MULTU) ||
                      (op == MD_DIV)  || (op == MD_DIVU);

    md_div_core u_div (
        .a_i      (a),
        .b_i      (b),
        .signed_i (op == MD_DIV),
        .quot_o   (div_quot),
        .rem_o    (div_rem),
        .dbz_o    (div_dbz)
    );

    always_comb begin
        pend_hi_d = '0;
        pend_lo_d = '0;
        pend_we_d = 1'b0;
        case (op)
            MD_MULT: begin
                {pend_hi_d, pend_lo_d} = prod_s;
                pend_we_d = 1'b1;
            end
            MD_MULTU: begin
                {pend_hi_d, pend_lo_d} = prod_u;
                pend_we_d = 1'b1;
            end
            MD_DIV, MD_DIVU: begin
                pend_hi_d = div_rem;
                pend_lo_d = div_quot;
                // Divide by zero still occupies the unit but leaves HI/LO alone.
                pend_we_d = ~div_dbz;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= MD_IDLE;
            busy_q    <= 1'b0;
            cnt_q     <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            pend_hi_q <= '0;
            pend_lo_q <= '0;
            pend_we_q <= 1'b0;
        end else begin
            case (state_q)
                MD_IDLE: begin
                    if (start) begin
                        if (is_md_op) begin
                            pend_hi_q <= pend_hi_d;
                            pend_lo_q <= pend_lo_d;
                            pend_we_q <= pend_we_d;
                            cnt_q     <= ((op == MD_DIV) || (op == MD_DIVU)) ?
                                         CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
                            busy_q    <= 1'b1;
                            state_q   <= MD_RUN;
                        end else if (op == MD_MTHI) begin
                            hi_q <= a;
                        end else if (op == MD_MTLO) begin
                            lo_q <= a;
                        end
                    end
                end
                MD_RUN: begin
                    cnt_q <= cnt_q - 1'b1;
                    if (cnt_q == CNT_W'(1)) begin
                        if (pend_we_q) begin
                            hi_q <= pend_hi_q;
                            lo_q <= pend_lo_q;
                        end
                        busy_q  <= 1'b0;
                        state_q <= MD_IDLE;
                    end
                end
                default: state_q <= MD_IDLE;
            endcase
        end
    end

    assign busy = busy_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule
